// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the serial BCD adder/subtractor.
package bcd_pkg;

  localparam int          BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  BCD_CORR    = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Nines complement of one decimal digit; meaningless for nibbles above 9,
  // which are flagged separately as invalid input.
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: binary add of two digits plus carry, +6 correction when the sum exceeds 9.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;

  // Binary sum then decimal correction into the 0..9 range
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > {1'b0, BCD_MAX}) begin
      s    = sum[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first, start/busy/done handshake.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            sub,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] b,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] result,
  output logic                            cout,
  output logic                            err
);

  localparam int W  = BCD_DIGIT_W * N_DIGITS;
  localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           sub_r;
  logic           err_run;
  logic [W-1:0]   a_r, b_r, res_sh, res_nx;

  logic           accept, last, bad, err_now;
  logic [3:0]     dig_a, dig_b, dig_s;
  logic           dig_c;
  int             idx;

  // Start is honoured only when no operation is in flight (IDLE or DONE)
  assign accept = start && (state != ST_RUN);
  assign last   = (cnt == CW'(N_DIGITS - 1));
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  // Select the current digit pair; subtraction uses the nines complement of B
  always_comb begin
    idx   = int'(cnt) * BCD_DIGIT_W;
    dig_a = a_r[idx +: BCD_DIGIT_W];
    dig_b = sub_r ? nines_comp(b_r[idx +: BCD_DIGIT_W]) : b_r[idx +: BCD_DIGIT_W];
  end

  bcd_digit_adder u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Shadow result with the current digit merged in at its position
  always_comb begin
    res_nx = res_sh;
    res_nx[idx +: BCD_DIGIT_W] = dig_s;
  end

  // Invalid-nibble scan over the captured operands
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (a_r[k*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX ||
          b_r[k*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)
        bad = 1'b1;
    end
  end

  // The scan result is latched in the first RUN cycle; that cycle may also be the last
  assign err_now = (cnt == '0) ? bad : err_run;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, per-digit accumulation and output update on the final digit
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 1'b0;
      err_run <= 1'b0;
      res_sh  <= '0;
      result  <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      sub_r  <= sub;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= sub;
    end else if (state == ST_RUN) begin
      res_sh <= res_nx;
      carry  <= dig_c;
      cnt    <= cnt + CW'(1);
      if (cnt == '0) err_run <= bad;
      if (last) begin
        result <= err_now ? '0 : res_nx;
        cout   <= err_now ? 1'b0 : (sub_r ? ~dig_c : dig_c);
        err    <= err_now;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub at N_DIGITS = 4, 1 and 8 against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st[3];
  logic        sb[3];
  logic [15:0] a0, b0;
  logic [3:0]  a1, b1;
  logic [31:0] a2, b2;
  logic        bz[3], dn[3], co[3], er[3];
  logic [15:0] r0;
  logic [3:0]  r1;
  logic [31:0] r2;
  logic [31:0] rs[3];

  assign rs[0] = {16'h0, r0};
  assign rs[1] = {28'h0, r1};
  assign rs[2] = r2;

  bcd_serial_addsub #(.N_DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(a0), .b(b0),
    .busy(bz[0]), .done(dn[0]), .result(r0), .cout(co[0]), .err(er[0]));
  bcd_serial_addsub #(.N_DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(a1), .b(b1),
    .busy(bz[1]), .done(dn[1]), .result(r1), .cout(co[1]), .err(er[1]));
  bcd_serial_addsub #(.N_DIGITS(8)) u8 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(a2), .b(b2),
    .busy(bz[2]), .done(dn[2]), .result(r2), .cout(co[2]), .err(er[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    int          dcyc;
    logic [31:0] res;
    logic        c;
    logic        e;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_r[3];
  logic        last_c[3];
  logic        last_e[3];

  function automatic int ndig(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode to integers, do decimal arithmetic, re-encode.
  task automatic model(input int n, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic e);
    longint av = 0, bv = 0, p = 1, t;
    e = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (a[4*k +: 4] > 9 || b[4*k +: 4] > 9) e = 1'b1;
      av += longint'(a[4*k +: 4]) * p;
      bv += longint'(b[4*k +: 4]) * p;
      p  *= 10;
    end
    r = '0;
    c = 1'b0;
    if (!e) begin
      if (!s) begin
        t = av + bv;
        c = (t >= p);
        t = t % p;
      end else if (av >= bv) begin
        t = av - bv;
      end else begin
        t = p + av - bv;
        c = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
        r[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
  endtask

  // Monitor: scoreboard on done, output-hold check on every other cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin
        last_r[i] = '0;
        last_c[i] = 1'b0;
        last_e[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          if (q.size() == 0 || q[0].inst != i) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done inst%0d: got done=1 expected no done", i);
          end else begin
            cur = q.pop_front();
            chk($sformatf("done_cycle inst%0d", i), 32'(cyc), 32'(cur.dcyc));
            chk($sformatf("result inst%0d", i), rs[i], cur.res);
            chk($sformatf("cout inst%0d", i), 32'(co[i]), 32'(cur.c));
            chk($sformatf("err inst%0d", i), 32'(er[i]), 32'(cur.e));
            chk($sformatf("busy_at_done inst%0d", i), 32'(bz[i]), 32'd0);
          end
          last_r[i] = rs[i];
          last_c[i] = co[i];
          last_e[i] = er[i];
        end else begin
          chk($sformatf("hold_result inst%0d", i), rs[i], last_r[i]);
          chk($sformatf("hold_flags inst%0d", i), {30'd0, co[i], er[i]}, {30'd0, last_c[i], last_e[i]});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    case (i)
      0: begin a0 = a[15:0]; b0 = b[15:0]; end
      1: begin a1 = a[3:0];  b1 = b[3:0];  end
      default: begin a2 = a; b2 = b; end
    endcase
    sb[i] = s;
  endtask

  // Called just after a rising edge; start is accepted at the next edge
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int dc);
    exp_t e;
    drive(i, a, b, s);
    st[i] = 1'b1;
    dc = cyc + 1 + ndig(i);
    e.inst = i;
    e.dcyc = dc;
    model(ndig(i), a, b, s, e.res, e.c, e.e);
    q.push_back(e);
    tick(1);
    st[i] = 1'b0;
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    int dc;
    issue(i, a, b, s, dc);
    wait_until(dc + 1);
  endtask

  function automatic logic [31:0] rand_bcd(input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, dc2, n, guard;
    logic [31:0] ra, rb;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      sb[i] = 1'b0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy inst%0d", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset_done inst%0d", i), 32'(dn[i]), 32'd0);
      chk($sformatf("reset_result inst%0d", i), rs[i], 32'd0);
    end
    tick(1);

    // 1234 + 5678: busy in cycles 1..4, done in cycle 5
    issue(0, 32'h1234, 32'h5678, 1'b0, dc);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("busy_cycle%0d", c), {31'd0, bz[0]}, 32'd1);
      chk($sformatf("nodone_cycle%0d", c), {31'd0, dn[0]}, 32'd0);
      tick(1);
    end
    @(negedge clk);
    chk("done_cycle5", {31'd0, dn[0]}, 32'd1);
    chk("add_1234_5678", {16'h0, r0}, 32'h6912);
    tick(1);

    run_op(0, 32'h9999, 32'h0001, 1'b0);
    run_op(0, 32'h0000, 32'h0000, 1'b0);
    run_op(0, 32'h0500, 32'h0123, 1'b1);
    run_op(0, 32'h0123, 32'h0500, 1'b1);
    run_op(0, 32'h4321, 32'h4321, 1'b1);
    run_op(0, 32'h12A4, 32'h0001, 1'b0);
    run_op(0, 32'h0042, 32'h0058, 1'b0);

    // Start while busy is ignored; start in the done cycle is taken back-to-back
    issue(0, 32'h1111, 32'h2222, 1'b0, dc);
    tick(1);
    drive(0, 32'h9876, 32'h5432, 1'b1);
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    wait_until(dc);
    issue(0, 32'h3333, 32'h4444, 1'b1, dc2);
    wait_until(dc2 + 1);

    // Reset in cycle 3 aborts the operation
    issue(0, 32'h5555, 32'h1234, 1'b0, dc);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bz[0]}, 32'd0);
    chk("abort_done", {31'd0, dn[0]}, 32'd0);
    chk("abort_result", {16'h0, r0}, 32'd0);
    tick(10);

    // Width extremes
    run_op(1, 32'h7, 32'h5, 1'b0);
    run_op(1, 32'h3, 32'h8, 1'b1);
    run_op(2, 32'h99999999, 32'h00000001, 1'b0);
    run_op(2, 32'h12345678, 32'h87654321, 1'b1);

    // Randomized operations, some back-to-back, some with an invalid nibble
    for (int i = 0; i < 3; i++) begin
      n = ndig(i);
      for (int t = 0; t < 40; t++) begin
        ra = rand_bcd(n);
        rb = rand_bcd(n);
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0)
            ra[4*$urandom_range(0, n-1) +: 4] = 4'($urandom_range(10, 15));
          else
            rb[4*$urandom_range(0, n-1) +: 4] = 4'($urandom_range(10, 15));
        end
        issue(i, ra, rb, 1'($urandom_range(0, 1)), dc);
        if ($urandom_range(0, 1) == 0) wait_until(dc);
        else wait_until(dc + 1 + $urandom_range(0, 3));
      end
      wait_until(dc + 2);
    end

    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
